seg_display_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment controller for the register-file processor. It is the successor to the fixed 4-digit display block.
- Drives NUM_DIGITS common-anode digits from a flattened register-file snapshot.
- Modes: blank, arithmetic operand view (srcA/srcB/dst), timed register scan, and a new paused scan (HOLD).
- Sits between the controller/decoder (mode, operand fields) and the board anode/segment pins.

---
 rtl/seg_display_pkg.sv | 25 ++
 rtl/seg_display_ctrl_if.sv | 28 ++
 rtl/hex7seg.sv | 11 +
 rtl/seg_display_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and glyph data for the multiplexed seven-segment controller.
package seg_display_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ARITH = 2'd1,
    MODE_SCAN  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; b and d are the lower-case forms.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Controller-side and pin-side signals of the seven-segment display block.
interface seg_display_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MEM_DEPTH  = 8
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [1:0]             mode;
  logic [AW-1:0]          src_a;
  logic [AW-1:0]          src_b;
  logic [AW-1:0]          dst;
  logic [4*MEM_DEPTH-1:0] mem_flat;
  logic [6:0]             seg;
  logic [NUM_DIGITS-1:0]  an;
  logic [AW-1:0]          scan_addr;
  logic                   scan_wrap;

  modport master (
    output mode, src_a, src_b, dst, mem_flat,
    input  seg, an, scan_addr, scan_wrap
  );

  modport slave (
    input  mode, src_a, src_b, dst, mem_flat,
    output seg, an, scan_addr, scan_wrap
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment glyph.
module hex7seg
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = glyph_of(nibble_i);

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode display driver with operand view and timed register scan.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100_000,
  parameter int STEP_DIV    = 100_000_000,
  parameter int MEM_DEPTH   = 8,
  parameter int AW          = $clog2(MEM_DEPTH)
) (
  input logic CLK,
  input logic reset,
  seg_display_ctrl_if.slave bus
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int SW = $clog2(STEP_DIV + 1);

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(MEM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [DW-1:0] TOP_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] SUB_DIGIT = DW'(NUM_DIGITS - 2);

  logic [3:0] mem_arr [MEM_DEPTH];

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_mem
    assign mem_arr[gi] = bus.mem_flat[4*gi +: 4];
  end

  mode_e mode_in;
  assign mode_in = mode_e'(bus.mode);

  logic [RW-1:0] refresh_q, refresh_d;
  logic [DW-1:0] digit_q,   digit_d;

  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      digit_d   = (digit_q == TOP_DIGIT) ? '0 : digit_q + DW'(1);
    end
  end

  mode_e         prev_mode_q;
  logic [SW-1:0] step_q,      step_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic          scan_wrap_q, scan_wrap_d;
  logic [AW:0]   end_sum;
  logic [AW-1:0] end_addr;
  logic          entering_scan;

  // End address is clipped to the last register when src_a + dst overflows the file.
  assign end_sum       = {1'b0, bus.src_a} + {1'b0, bus.dst};
  assign end_addr      = (end_sum >= DEPTH_EXT) ? LAST_ADDR : end_sum[AW-1:0];
  assign entering_scan = (prev_mode_q == MODE_OFF) || (prev_mode_q == MODE_ARITH);

  always_comb begin
    step_d      = step_q;
    scan_addr_d = scan_addr_q;
    scan_wrap_d = 1'b0;
    unique case (mode_in)
      MODE_SCAN: begin
        if (entering_scan) begin
          scan_addr_d = bus.src_a;
          step_d      = '0;
        end else if (step_q == SW'(STEP_DIV - 1)) begin
          step_d = '0;
          if ((scan_addr_q == end_addr) || (scan_addr_q == LAST_ADDR)) begin
            scan_addr_d = bus.src_a;
            scan_wrap_d = 1'b1;
          end else begin
            scan_addr_d = scan_addr_q + AW'(1);
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      MODE_HOLD: begin
        step_d = step_q;
      end
      default: begin
        step_d = '0;
      end
    endcase
  end

  logic [3:0]            nibble_sel;
  logic                  show_digit;
  logic [6:0]            glyph;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q,  an_d;

  always_comb begin
    nibble_sel = '0;
    show_digit = 1'b0;
    unique case (mode_in)
      MODE_ARITH: begin
        if (digit_q == TOP_DIGIT) begin
          nibble_sel = mem_arr[bus.src_a];
          show_digit = 1'b1;
        end else if (digit_q == SUB_DIGIT) begin
          nibble_sel = mem_arr[bus.src_b];
          show_digit = 1'b1;
        end else if (digit_q == '0) begin
          nibble_sel = mem_arr[bus.dst];
          show_digit = 1'b1;
        end
      end
      MODE_SCAN, MODE_HOLD: begin
        if (digit_q == TOP_DIGIT) begin
          nibble_sel = 4'(scan_addr_q);
          show_digit = 1'b1;
        end else if (digit_q == '0) begin
          nibble_sel = mem_arr[scan_addr_q];
          show_digit = 1'b1;
        end
      end
      default: begin
        show_digit = 1'b0;
      end
    endcase
  end

  hex7seg u_hex7seg (
    .nibble_i (nibble_sel),
    .glyph_o  (glyph)
  );

  // Segments and anode are registered from the same digit index so they switch together.
  always_comb begin
    seg_d = show_digit ? glyph : SEG_BLANK;
    an_d  = ~(NUM_DIGITS'(1) << digit_q);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      refresh_q   <= '0;
      digit_q     <= '0;
      step_q      <= '0;
      scan_addr_q <= '0;
      scan_wrap_q <= 1'b0;
      prev_mode_q <= MODE_OFF;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
      step_q      <= step_d;
      scan_addr_q <= scan_addr_d;
      scan_wrap_q <= scan_wrap_d;
      prev_mode_q <= mode_in;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.scan_addr = scan_addr_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench: display tables, scan corner sequences and a randomized run against a model.
module tb_seg_display_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int SD = 16;
  localparam int MD = 8;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] d;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  logic clk;
  logic rst_n;

  seg_display_ctrl_if #(.NUM_DIGITS(ND), .MEM_DEPTH(MD)) bus ();

  seg_display_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .STEP_DIV    (SD),
    .MEM_DEPTH   (MD)
  ) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  int         mem_tb   [MD];
  logic [6:0] glyph_tb [16];
  logic [3:0] an_seq   [4];
  logic [3:0] one4;

  int         m_k;
  int         m_addr;
  int         m_phase;
  int         m_prev;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic [3:0] m_an;

  int seq_q [$];
  int chg_q [$];
  int wrap_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k     = 0;
    m_addr  = 0;
    m_phase = 0;
    m_prev  = 0;
    m_wrap  = 1'b0;
    m_seg   = 7'h7F;
    m_an    = 4'hF;
  endtask

  function automatic logic [6:0] exp_glyph(input int md, input int digit, input int addr);
    logic [6:0] g;
    g = 7'h7F;
    if (md == 1) begin
      if (digit == ND-1)      g = glyph_tb[mem_tb[bus.src_a]];
      else if (digit == ND-2) g = glyph_tb[mem_tb[bus.src_b]];
      else if (digit == 0)    g = glyph_tb[mem_tb[bus.dst]];
    end else if (md >= 2) begin
      if (digit == ND-1)      g = glyph_tb[addr];
      else if (digit == 0)    g = glyph_tb[mem_tb[addr]];
    end
    return g;
  endfunction

  // One clock: advance the reference from the inputs seen at the edge, then compare all outputs.
  task automatic cyc();
    int digit;
    int md;
    int end_a;
    @(posedge clk);
    if (rst_n) begin
      md     = int'(bus.mode);
      digit  = (m_k / RD) % ND;
      m_seg  = exp_glyph(md, digit, m_addr);
      m_an   = ~(one4 << digit);
      m_k++;
      m_wrap = 1'b0;
      if (md == 2) begin
        if (m_prev <= 1) begin
          m_addr  = int'(bus.src_a);
          m_phase = 0;
        end else begin
          m_phase++;
          if (m_phase == SD) begin
            m_phase = 0;
            end_a = int'(bus.src_a) + int'(bus.dst);
            if (end_a > MD-1) end_a = MD-1;
            if (m_addr == end_a || m_addr == MD-1) begin
              m_addr = int'(bus.src_a);
              m_wrap = 1'b1;
            end else begin
              m_addr++;
            end
          end
        end
      end else if (md != 3) begin
        m_phase = 0;
      end
      m_prev = md;
    end
    #1;
    check("an", bus.an, m_an);
    check("seg", bus.seg, m_seg);
    check("scan_addr", bus.scan_addr, m_addr);
    check("scan_wrap", bus.scan_wrap, m_wrap);
  endtask

  task automatic scan_run(input int a, input int d, input int ncyc);
    int last;
    bus.mode  = 2'd2;
    bus.src_a = 3'(a);
    bus.dst   = 3'(d);
    seq_q.delete();
    chg_q.delete();
    wrap_cnt = 0;
    last = -1;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (int'(bus.scan_addr) != last) begin
        last = int'(bus.scan_addr);
        seq_q.push_back(last);
        chg_q.push_back(i);
      end
      if (bus.scan_wrap) begin
        wrap_cnt++;
        check("wrap_to_start", bus.scan_addr, a);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before t=%0t", $time);
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    vec_t tbl [10];
    bit   found;
    int   saved;
    int   n;

    one4 = 4'b0001;
    for (int i = 0; i < MD; i++) mem_tb[i] = (i + 9) % 16;
    glyph_tb[0]  = 7'h40; glyph_tb[1]  = 7'h79; glyph_tb[2]  = 7'h24; glyph_tb[3]  = 7'h30;
    glyph_tb[4]  = 7'h19; glyph_tb[5]  = 7'h12; glyph_tb[6]  = 7'h02; glyph_tb[7]  = 7'h78;
    glyph_tb[8]  = 7'h00; glyph_tb[9]  = 7'h10; glyph_tb[10] = 7'h08; glyph_tb[11] = 7'h03;
    glyph_tb[12] = 7'h46; glyph_tb[13] = 7'h21; glyph_tb[14] = 7'h06; glyph_tb[15] = 7'h0E;
    an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;

    tbl[0] = '{2'd1, 3'd2, 3'd5, 3'd7, 4'b0111, 7'h03};
    tbl[1] = '{2'd1, 3'd2, 3'd5, 3'd7, 4'b1011, 7'h06};
    tbl[2] = '{2'd1, 3'd2, 3'd5, 3'd7, 4'b1101, 7'h7F};
    tbl[3] = '{2'd1, 3'd2, 3'd5, 3'd7, 4'b1110, 7'h40};
    tbl[4] = '{2'd1, 3'd0, 3'd7, 3'd3, 4'b0111, 7'h10};
    tbl[5] = '{2'd1, 3'd0, 3'd7, 3'd3, 4'b1011, 7'h40};
    tbl[6] = '{2'd1, 3'd0, 3'd7, 3'd3, 4'b1101, 7'h7F};
    tbl[7] = '{2'd1, 3'd0, 3'd7, 3'd3, 4'b1110, 7'h46};
    tbl[8] = '{2'd0, 3'd0, 3'd0, 3'd0, 4'b1110, 7'h7F};
    tbl[9] = '{2'd0, 3'd0, 3'd0, 3'd0, 4'b0111, 7'h7F};

    for (int i = 0; i < MD; i++) bus.mem_flat[4*i +: 4] = 4'(mem_tb[i]);
    bus.mode  = 2'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.dst   = '0;

    // Reset held for three clocks, then the anode walk with blank segments.
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_an", bus.an, 4'hF);
      check("rst_seg", bus.seg, 7'h7F);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i % 4 == 0) check("rst_an_step", bus.an, an_seq[i/4]);
      check("off_seg", bus.seg, 7'h7F);
    end

    // Table of display vectors: wait for the anode, then compare the glyph.
    for (int t = 0; t < 10; t++) begin
      bus.mode  = tbl[t].mode;
      bus.src_a = tbl[t].a;
      bus.src_b = tbl[t].b;
      bus.dst   = tbl[t].d;
      found = 1'b0;
      for (int w = 0; w < 2*ND*RD && !found; w++) begin
        cyc();
        if (bus.an === tbl[t].an) found = 1'b1;
      end
      check("tbl_an_seen", found, 1'b1);
      if (found) check("tbl_seg", bus.seg, tbl[t].seg);
    end

    // Wrap at programmed end: 5,6,5,6 every 16 clocks.
    scan_run(5, 1, 70);
    check("wrap_seq_len", (seq_q.size() >= 4), 1'b1);
    if (seq_q.size() >= 4) begin
      for (int j = 0; j < 4; j++) check("wrap_seq", seq_q[j], (j % 2 == 0) ? 5 : 6);
      for (int j = 1; j < 4; j++) check("wrap_period", chg_q[j] - chg_q[j-1], 16);
    end
    check("wrap_count", wrap_cnt, 2);

    // Clip at the last register: 6,7,6.
    bus.mode = 2'd0;
    cyc();
    scan_run(6, 5, 40);
    check("clip_seq_len", (seq_q.size() >= 3), 1'b1);
    if (seq_q.size() >= 3) begin
      for (int j = 0; j < 3; j++) check("clip_seq", seq_q[j], (j == 1) ? 7 : 6);
    end
    check("clip_wrap_count", wrap_cnt, 1);

    // Pause at step count 10 for 40 clocks, then resume without reload.
    found = 1'b0;
    for (int w = 0; w < 2*SD && !found; w++) begin
      cyc();
      if (m_phase == 10) found = 1'b1;
    end
    check("hold_align", found, 1'b1);
    saved = int'(bus.scan_addr);
    bus.mode = 2'd3;
    for (int i = 0; i < 40; i++) begin
      cyc();
      check("hold_addr", bus.scan_addr, saved);
      check("hold_wrap", bus.scan_wrap, 1'b0);
    end
    bus.mode = 2'd2;
    n = 0;
    found = 1'b0;
    for (int w = 0; w < 2*SD && !found; w++) begin
      cyc();
      n++;
      if (int'(bus.scan_addr) != saved || bus.scan_wrap) found = 1'b1;
    end
    check("resume_seen", found, 1'b1);
    check("resume_delay", n, 6);

    // Randomized mode and operand changes against the reference model.
    for (int s = 0; s < 24; s++) begin
      bus.mode  = 2'($urandom_range(0, 3));
      bus.src_a = 3'($urandom_range(0, 7));
      bus.src_b = 3'($urandom_range(0, 7));
      bus.dst   = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) cyc();
    end

    // Asynchronous reset between clock edges in the middle of a scan.
    bus.mode = 2'd0;
    cyc();
    bus.mode  = 2'd2;
    bus.src_a = 3'd3;
    bus.dst   = 3'd4;
    for (int i = 0; i < 20; i++) cyc();
    check("pre_reset_addr", bus.scan_addr, 3'd4);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_an", bus.an, 4'hF);
    check("async_seg", bus.seg, 7'h7F);
    check("async_scan_addr", bus.scan_addr, 3'd0);
    check("async_scan_wrap", bus.scan_wrap, 1'b0);
    for (int i = 0; i < 2; i++) cyc();
    rst_n = 1'b1;
    bus.mode = 2'd1;
    for (int i = 0; i < 20; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
